// File: rtl/mux_sel_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_arbiter_if
//  Description : Bundle between the two requesters and the arbiter that
//                steers the shared 2:1 data mux.
//                  req0/req1 : requester wants the shared path
//                  done      : current owner finished its transfer
//                  sel       : mux select (0 -> d0, 1 -> d1)
//                  gnt0/gnt1 : ownership indication per requester
//                  busy      : a grant is active
//                  preempt   : one-cycle pulse after a timeout release
//                master : requester side (drives req/done)
//                slave  : arbiter side (drives sel/grants/status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_sel_arbiter_if;
    logic req0;
    logic req1;
    logic done;
    logic sel;
    logic gnt0;
    logic gnt1;
    logic busy;
    logic preempt;

    modport master (
        output req0,
        output req1,
        output done,
        input  sel,
        input  gnt0,
        input  gnt1,
        input  busy,
        input  preempt
    );

    modport slave (
        input  req0,
        input  req1,
        input  done,
        output sel,
        output gnt0,
        output gnt1,
        output busy,
        output preempt
    );
endinterface
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_arbiter
//  Description : Two-way round-robin arbiter placed in front of a 2:1 data
//                mux. A grant is held for a whole transfer (ended by done or
//                by the owner dropping its request). When HOLD_MAX is non-zero
//                an owner that has held the path for HOLD_MAX cycles while
//                the other side waits is preempted.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - slave modport of mux_sel_arbiter_if
//                       (req0, req1, done in; sel, gnt0, gnt1, busy,
//                        preempt out, all outputs registered)
//  Parameters  : HOLD_MAX - grant cycles before preemption, 0 disables
//                CNT_W    - hold counter width, 2**CNT_W > HOLD_MAX
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mux_sel_arbiter_if.slave bus
);

    // ------------------------------------------------------------------
    // Elaboration-time sanity check on the counter width
    // ------------------------------------------------------------------
    generate
        if ((HOLD_MAX < 0) || ((64'd1 << CNT_W) <= 64'(HOLD_MAX))) begin : g_bad_cnt_w
            $error("mux_sel_arbiter: CNT_W too narrow for HOLD_MAX");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_g0   = 2'd1;
    localparam logic [1:0] c_g1   = 2'd2;

    localparam logic             c_to_en     = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W-1:0] c_hold_last = c_to_en ? CNT_W'(HOLD_MAX - 1) : '0;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;      // side granted most recently; loses the next tie
    logic             r_sel;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_busy;
    logic             r_preempt;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_last_nxt;
    logic             w_preempt_nxt;
    logic             w_own_req;
    logic             w_oth_req;
    logic             w_timeout;
    logic             w_release;
    logic             w_sel_nxt;
    logic             w_gnt0_nxt;
    logic             w_gnt1_nxt;
    logic             w_busy_nxt;

    // ------------------------------------------------------------------
    // State register (outputs are registered alongside the state so that
    // the mux select and grants come straight from flops)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_idle;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_sel     <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
            r_sel     <= w_sel_nxt;
            r_gnt0    <= w_gnt0_nxt;
            r_gnt1    <= w_gnt1_nxt;
            r_busy    <= w_busy_nxt;
            r_preempt <= w_preempt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_last_nxt    = r_last;
        w_preempt_nxt = 1'b0;
        w_timeout     = 1'b0;
        w_release     = 1'b0;
        w_own_req     = (r_state == c_g1) ? bus.req1 : bus.req0;
        w_oth_req     = (r_state == c_g1) ? bus.req0 : bus.req1;

        case (r_state)
            c_idle: begin
                w_cnt_nxt = '0;
                if (bus.req0 && bus.req1) begin
                    w_state_nxt = r_last ? c_g0 : c_g1;
                end else if (bus.req0) begin
                    w_state_nxt = c_g0;
                end else if (bus.req1) begin
                    w_state_nxt = c_g1;
                end
            end

            c_g0, c_g1: begin
                w_timeout = c_to_en && (r_cnt == c_hold_last) && w_oth_req;
                w_release = bus.done || !w_own_req || w_timeout;
                if (w_release) begin
                    w_cnt_nxt = '0;
                    if (w_oth_req) begin
                        // Hand over directly, no idle cycle in between.
                        w_state_nxt   = (r_state == c_g1) ? c_g0 : c_g1;
                        // Only a pure timeout counts as a preemption; done
                        // or a dropped request take precedence.
                        w_preempt_nxt = w_timeout && !bus.done && w_own_req;
                    end else if (w_own_req && bus.done) begin
                        // Back-to-back transfer by the same owner.
                        w_state_nxt = r_state;
                    end else begin
                        w_state_nxt = c_idle;
                    end
                end else if (r_cnt != c_cnt_max) begin
                    // Saturate so a long solo owner never re-hits the
                    // timeout compare through wrap-around.
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = c_idle;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_state_nxt == c_g0) begin
            w_last_nxt = 1'b0;
        end else if (w_state_nxt == c_g1) begin
            w_last_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (from the next state, registered above)
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt0_nxt = (w_state_nxt == c_g0);
        w_gnt1_nxt = (w_state_nxt == c_g1);
        w_busy_nxt = w_gnt0_nxt || w_gnt1_nxt;
        // sel keeps the last granted side while idle so the mux output
        // does not toggle.
        w_sel_nxt  = r_sel;
        if (w_gnt0_nxt) begin
            w_sel_nxt = 1'b0;
        end else if (w_gnt1_nxt) begin
            w_sel_nxt = 1'b1;
        end
    end

    assign bus.sel     = r_sel;
    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.busy    = r_busy;
    assign bus.preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_sel_arbiter
//  Description : Self-checking bench for mux_sel_arbiter. Directed stimulus
//                pushes expected output vectors {gnt0,gnt1,sel,busy,preempt}
//                tagged with the cycle they must appear in; a monitor on the
//                falling edge pops and compares them and also checks the
//                grant invariants every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    mux_sel_arbiter_if bus ();

    mux_sel_arbiter #(
        .HOLD_MAX (16),
        .CNT_W    (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    logic [4:0] obs;
    assign obs = {bus.gnt0, bus.gnt1, bus.sel, bus.busy, bus.preempt};

    typedef struct {
        int         cyc;
        string      name;
        logic [4:0] exp;
    } exp_t;

    exp_t sb_q[$];

    // Expected vector for the cycle 'off' falling edges ahead of now.
    task automatic push_exp(input string nm, input logic [4:0] v, input int off);
        exp_t e;
        e.cyc  = cyc + off;
        e.name = nm;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    // Inputs applied just after a rising edge, sampled on the next one.
    task automatic drive(input logic r0, input logic r1, input logic d);
        @(posedge clk);
        #1;
        bus.req0 = r0;
        bus.req1 = r1;
        bus.done = d;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.done = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        n_checks++;
        if (bus.gnt0 && bus.gnt1) begin
            n_fail++;
            $display("FAIL onehot cyc=%0d gnt0=%b gnt1=%b required not both 1", cyc, bus.gnt0, bus.gnt1);
        end
        n_checks++;
        if (bus.busy !== (bus.gnt0 | bus.gnt1)) begin
            n_fail++;
            $display("FAIL busy_eq cyc=%0d busy=%b required %b", cyc, bus.busy, bus.gnt0 | bus.gnt1);
        end
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s stale entry cyc=%0d required cyc=%0d", e.name, cyc, e.cyc);
            end else if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc=%0d {g0,g1,sel,busy,pre} got %b required %b", e.name, cyc, obs, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.done = 1'b0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        drive(0, 0, 0); push_exp("rst_idle", 5'b00000, 1);

        // Single requester, release by done with req dropped
        drive(1, 0, 0); push_exp("s1_gnt0",      5'b10010, 1);
        drive(0, 0, 1); push_exp("s1_idle",      5'b00000, 1);
        drive(0, 0, 0); push_exp("s1_idle_hold", 5'b00000, 1);

        // Both held from reset: alternation over four transfers
        do_reset();
        drive(1, 1, 0); push_exp("s2_first_g0", 5'b10010, 1);
        drive(1, 1, 1); push_exp("s2_swap_g1",  5'b01110, 1);
        drive(1, 1, 0); push_exp("s2_hold_g1",  5'b01110, 1);
        drive(1, 1, 1); push_exp("s2_swap_g0",  5'b10010, 1);
        drive(1, 1, 1); push_exp("s2_swap_g1b", 5'b01110, 1);
        drive(0, 0, 1); push_exp("s2_idle_sel1", 5'b00100, 1);

        // Timeout preemption: gnt0 held exactly 16 cycles
        drive(1, 0, 0); push_exp("s3_gnt0", 5'b10010, 1);
        drive(1, 1, 0);
        for (int i = 1; i <= 15; i++) push_exp("s3_hold_g0", 5'b10010, i);
        push_exp("s3_preempt",  5'b01111, 16);
        push_exp("s3_g1_after", 5'b01110, 17);
        repeat (17) drive(1, 1, 0);
        drive(0, 0, 1); push_exp("s3_idle", 5'b00100, 1);

        // Solo owner 40 cycles, then other side waits: saturated counter
        // must not come back round to the timeout value.
        drive(1, 0, 0);
        for (int i = 1; i <= 41; i++) push_exp("s4_solo_g0", 5'b10010, i);
        repeat (40) drive(1, 0, 0);
        for (int i = 2; i <= 21; i++) push_exp("s4_sat_g0", 5'b10010, i);
        repeat (20) drive(1, 1, 0);
        drive(1, 1, 1); push_exp("s4_done_g1", 5'b01110, 1);
        drive(0, 0, 1); push_exp("s4_idle",    5'b00100, 1);

        // done coincides with timeout: ordinary handover, no preempt
        drive(1, 0, 0); push_exp("s5_gnt0", 5'b10010, 1);
        repeat (15) drive(1, 1, 0);
        drive(1, 1, 1); push_exp("s5_done_to_g1", 5'b01110, 1);
        drive(1, 1, 0); push_exp("s5_g1_nopre",   5'b01110, 1);
        @(posedge clk);
        @(negedge clk);

        // Asynchronous reset in the middle of G1
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 5'b00000) begin
            n_fail++;
            $display("FAIL s6_async_rst {g0,g1,sel,busy,pre} got %b required %b", obs, 5'b00000);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp("s6_gnt0_first", 5'b10010, 1);
        drive(0, 0, 1); push_exp("s6_idle",      5'b00000, 1);
        drive(0, 0, 0); push_exp("s6_idle_hold", 5'b00000, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain pending=%0d required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
